// File: rtl/aes_inv_key_stream.sv
// AES-128 decryption round-key source: expands the cipher key forward to round 10,
// then streams round keys 10..0 by undoing the schedule one round per accepted beat.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

module aes_inv_key_stream #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] key_reg;
  logic [3:0]   rc_cnt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p3;
  logic [31:0]  sub_in;
  logic [31:0]  rot;
  logic [31:0]  sub_out;
  logic [3:0]   rcon_idx;
  logic [31:0]  rcon_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] fwd_key;
  logic [127:0] bwd_key;

  function automatic logic [7:0] rcon_byte(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  assign {w0, w1, w2, w3} = key_reg;

  // One S-box word serves both directions: forward feeds W3, backward feeds the recovered W3.
  assign p3       = w3 ^ w2;
  assign sub_in   = (state == EMIT) ? p3 : w3;
  assign rot      = {sub_in[23:0], sub_in[31:24]};
  assign rcon_idx = (state == EMIT) ? rc_cnt : rc_cnt + 4'd1;
  assign rcon_w   = {rcon_byte(rcon_idx), 24'h0};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .y (sub_out[8*i +: 8])
    );
  end

  assign n0      = w0 ^ sub_out ^ rcon_w;
  assign n1      = n0 ^ w1;
  assign n2      = n1 ^ w2;
  assign n3      = n2 ^ w3;
  assign fwd_key = {n0, n1, n2, n3};
  assign bwd_key = {w0 ^ sub_out ^ rcon_w, w1 ^ w0, w2 ^ w1, p3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_valid) state_nxt = EXPAND;
      EXPAND:  if (rc_cnt == 4'(NR - 1)) state_nxt = EMIT;
      EMIT:    if (rk_ready && (rc_cnt == 4'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg <= '0;
      rc_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_reg <= key_in;
            rc_cnt  <= '0;
          end
        end
        EXPAND: begin
          key_reg <= fwd_key;
          rc_cnt  <= rc_cnt + 4'd1;
        end
        EMIT: begin
          if (rk_ready && (rc_cnt != 4'd0)) begin
            key_reg <= bwd_key;
            rc_cnt  <= rc_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    key_ready = (state == IDLE);
    busy      = (state != IDLE);
    rk_valid  = (state == EMIT);
    rk_out    = key_reg;
    rk_round  = rc_cnt;
    rk_last   = (state == EMIT) && (rc_cnt == 4'd0);
  end
endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Bench for aes_inv_key_stream: reference AES-128 key expansion with a GF(2^8)-derived S-box,
// a beat queue checked every cycle, and directed timing/reset/backpressure scenarios.

module tb_aes_inv_key_stream;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         busy;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] sbox_m [256];

  typedef struct {
    logic [127:0] k;
    logic [3:0]   r;
  } beat_t;
  beat_t q[$];
  bit m_busy = 1'b0;
  int m_wait = 0;

  aes_inv_key_stream #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  function automatic logic [127:0] model_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Per-cycle compare against the job model, then advance the model for the coming edge.
  initial begin
    bit m_emit;
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_emit = m_busy && (m_wait == 0);
      check("key_ready", 128'(key_ready), 128'(!m_busy));
      check("busy", 128'(busy), 128'(m_busy));
      check("rk_valid", 128'(rk_valid), 128'(m_emit));
      if (m_emit && rk_valid && (q.size() > 0)) begin
        check("rk_out", rk_out, q[0].k);
        check("rk_round", 128'(rk_round), 128'(q[0].r));
        check("rk_last", 128'(rk_last), 128'(q[0].r == 4'd0));
      end
      if (rst) begin
        q.delete();
        m_busy = 1'b0;
        m_wait = 0;
      end else if (!m_busy) begin
        if (key_valid) begin
          for (int r = 10; r >= 0; r--) q.push_back('{model_key(key_in, r), 4'(r)});
          m_busy = 1'b1;
          m_wait = 10;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (rk_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k, output int acc);
    acc       = cyc;
    key_in    = k;
    key_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (key_ready) begin
        tick();
        acc       = cyc;
        key_valid = 1'b0;
        return;
      end
      tick();
    end
    key_valid = 1'b0;
    timeout("send_key");
  endtask

  task automatic drain(input bit rand_ready, input bit noise);
    logic         pv, pr;
    logic [127:0] po;
    logic [3:0]   prd;
    for (int n = 0; n < 400; n++) begin
      rk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (noise && busy && !(rk_valid && (rk_round <= 4'd1))) begin
        key_valid = 1'($urandom_range(0, 1));
        key_in    = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        key_valid = 1'b0;
      end
      pv  = rk_valid;
      pr  = rk_ready;
      po  = rk_out;
      prd = rk_round;
      tick();
      if (pv && !pr) begin
        check("hold_rk_out", rk_out, po);
        check("hold_rk_round", 128'(rk_round), 128'(prd));
      end
      if (!busy) begin
        key_valid = 1'b0;
        return;
      end
    end
    key_valid = 1'b0;
    timeout("drain");
  endtask

  initial begin
    int acc, acc2, n;
    build_sbox();

    check("pin_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
    check("pin_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
    check("pin_model_a1_r10", model_key(KEY_A1, 10), A1_R10);
    check("pin_model_a1_r1", model_key(KEY_A1, 1), A1_R1);
    check("pin_model_a1_r0", model_key(KEY_A1, 0), KEY_A1);
    check("pin_model_zero_r10", model_key(128'h0, 10), ZERO_R10);
    check("pin_model_zero_r0", model_key(128'h0, 0), 128'h0);

    repeat (3) tick();
    check("reset_rk_out", rk_out, 128'h0);
    check("reset_rk_round", 128'(rk_round), 128'h0);
    check("reset_rk_last", 128'(rk_last), 128'h0);
    check("reset_rk_valid", 128'(rk_valid), 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    rst = 1'b0;
    tick();
    check("reset_key_ready", 128'(key_ready), 128'h1);

    // FIPS-197 A.1 key with the consumer always ready.
    rk_ready = 1'b1;
    send_key(KEY_A1, acc);
    n = 0;
    while (!rk_valid && n < 40) begin tick(); n++; end
    check("a1_first_beat_cycle", 128'(cyc - acc), 128'd10);
    check("a1_first_round", 128'(rk_round), 128'd10);
    check("a1_round10_key", rk_out, A1_R10);
    while (rk_valid && n < 80) begin
      if (rk_round == 4'd1) check("a1_round1_key", rk_out, A1_R1);
      if (rk_round == 4'd0) begin
        check("a1_round0_key", rk_out, KEY_A1);
        check("a1_round0_last", 128'(rk_last), 128'h1);
      end
      tick();
      n++;
    end
    check("a1_key_ready_cycle", 128'(cyc - acc), 128'd21);
    check("a1_key_ready_again", 128'(key_ready), 128'h1);

    // Same key under random backpressure.
    send_key(KEY_A1, acc);
    drain(1'b1, 1'b0);

    // All-zero key; key_valid noise while the job is running.
    send_key(128'h0, acc);
    key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    key_valid = 1'b0;
    check("zero_first_valid", 128'(rk_valid), 128'h1);
    check("zero_round10_key", rk_out, ZERO_R10);
    drain(1'b1, 1'b1);

    // Reset in the middle of expansion.
    send_key({$urandom, $urandom, $urandom, $urandom}, acc);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_expand_rk_valid", 128'(rk_valid), 128'h0);
    check("rst_expand_busy", 128'(busy), 128'h0);
    check("rst_expand_key_ready", 128'(key_ready), 128'h1);

    // Reset after three beats of a stream.
    rk_ready = 1'b1;
    send_key(KEY_A1, acc);
    n = 0;
    while (!rk_valid && n < 40) begin tick(); n++; end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_emit_rk_valid", 128'(rk_valid), 128'h0);
    check("rst_emit_busy", 128'(busy), 128'h0);
    check("rst_emit_key_ready", 128'(key_ready), 128'h1);
    send_key({$urandom, $urandom, $urandom, $urandom}, acc);
    drain(1'b1, 1'b0);

    // Back-to-back jobs with key_valid held high throughout.
    rk_ready  = 1'b1;
    key_in    = KEY_A1;
    key_valid = 1'b1;
    check("b2b_first_key_ready", 128'(key_ready), 128'h1);
    tick();
    acc    = cyc;
    key_in = 128'h0;
    n = 0;
    while (!key_ready && n < 40) begin tick(); n++; end
    check("b2b_second_accept_cycle", 128'(cyc - acc), 128'd21);
    tick();
    acc2      = cyc;
    key_valid = 1'b0;
    n = 0;
    while (!rk_valid && n < 40) begin tick(); n++; end
    check("b2b_second_first_beat_latency", 128'(cyc - acc2), 128'd10);
    check("b2b_second_round10_key", rk_out, ZERO_R10);
    drain(1'b0, 1'b0);

    // Random keys with random consumer readiness.
    for (int j = 0; j < 1000; j++) begin
      send_key({$urandom, $urandom, $urandom, $urandom}, acc);
      drain(1'b1, (j % 4) == 0);
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
